// File: rtl/rf_scoreboard_if.sv
// -----------------------------------------------------------------------------
// rf_scoreboard_if
//   Groups the decode/writeback-side signals of the register-file scoreboard.
//   The decode/writeback logic (or a testbench) uses the master modport and
//   the scoreboard uses the slave modport.
//
//   Decode side : src0_addr/src0_re, src1_addr/src1_re (mirror of file p0/p1),
//                 issue, issue_we, issue_addr
//   Writeback   : wb_we, wb_addr (mirror of file we/dst_addr)
//   Control     : flush (squash in-flight writes), hlt (debug dump request)
//   Results     : stall, busy0, busy1, pending[5:0], wb_err
// -----------------------------------------------------------------------------
interface rf_scoreboard_if;
  logic [3:0] src0_addr;
  logic       src0_re;
  logic [3:0] src1_addr;
  logic       src1_re;
  logic       issue;
  logic       issue_we;
  logic [3:0] issue_addr;
  logic       wb_we;
  logic [3:0] wb_addr;
  logic       flush;
  logic       hlt;
  logic       stall;
  logic       busy0;
  logic       busy1;
  logic [5:0] pending;
  logic       wb_err;

  modport master (
    output src0_addr, src0_re, src1_addr, src1_re,
    output issue, issue_we, issue_addr,
    output wb_we, wb_addr, flush, hlt,
    input  stall, busy0, busy1, pending, wb_err
  );

  modport slave (
    input  src0_addr, src0_re, src1_addr, src1_re,
    input  issue, issue_we, issue_addr,
    input  wb_we, wb_addr, flush, hlt,
    output stall, busy0, busy1, pending, wb_err
  );
endinterface

// File: rtl/rf_scoreboard.sv
// -----------------------------------------------------------------------------
// rf_scoreboard
//   Tracks register-file writes that have been issued but not yet written
//   back, and holds decode when a source operand is still outstanding or the
//   destination's outstanding-write counter is already saturated.
//   One saturating counter per architectural register; R0 is never tracked
//   (its counter is held at zero so lookups of R0 always read idle).
//
//   Ports
//     clk  : rising-edge clock
//     rst  : asynchronous active-high reset (clears counters, pending, wb_err)
//     sb   : rf_scoreboard_if.slave
//            inputs  src0/src1 address+enable, issue/issue_we/issue_addr,
//                    wb_we/wb_addr, flush, hlt
//            outputs stall, busy0, busy1 (combinational from state + decode
//                    inputs), pending, wb_err (registered)
// -----------------------------------------------------------------------------
module rf_scoreboard #(
  parameter int NUM_REGS = 16,
  parameter int CNT_W    = 2
) (
  input  logic            clk,
  input  logic            rst,
  rf_scoreboard_if.slave  sb
);

  localparam logic [CNT_W-1:0]    CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]    CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]    CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [NUM_REGS-1:0] ONEHOT0  = {{(NUM_REGS-1){1'b0}}, 1'b1};
  localparam logic [3:0]          REG_ZERO = 4'd0;

  // Architectural state
  logic [CNT_W-1:0] cnt_r [NUM_REGS];
  logic [5:0]       pending_r;
  logic             wb_err_r;

  // Next-state and decode
  logic [CNT_W-1:0]    cnt_nxt_s [NUM_REGS];
  logic [5:0]          pending_nxt_s;
  logic [CNT_W-1:0]    src0_cnt_s;
  logic [CNT_W-1:0]    src1_cnt_s;
  logic [CNT_W-1:0]    dst_cnt_s;
  logic [CNT_W-1:0]    wb_cnt_s;
  logic                busy0_s;
  logic                busy1_s;
  logic                full_hit_s;
  logic                stall_s;
  logic                inc_s;
  logic                dec_s;
  logic                underflow_s;
  logic [NUM_REGS-1:0] inc_vec_s;
  logic [NUM_REGS-1:0] dec_vec_s;

  // The halt dump is a simulation-log convenience handled outside the
  // synthesizable datapath; the request has no functional effect here.
  logic unused_hlt_s;
  assign unused_hlt_s = sb.hlt;

  // Counter lookups for every port that consults the scoreboard
  assign src0_cnt_s = cnt_r[sb.src0_addr];
  assign src1_cnt_s = cnt_r[sb.src1_addr];
  assign dst_cnt_s  = cnt_r[sb.issue_addr];
  assign wb_cnt_s   = cnt_r[sb.wb_addr];

  // Hazard detection: operand busy, destination counter saturated, and the
  // resulting stall. Deliberately independent of the writeback inputs: a
  // read in its writeback cycle still stalls because the file only makes
  // the data readable one cycle later.
  always_comb begin
    busy0_s    = sb.src0_re && (sb.src0_addr != REG_ZERO) && (src0_cnt_s != CNT_ZERO);
    busy1_s    = sb.src1_re && (sb.src1_addr != REG_ZERO) && (src1_cnt_s != CNT_ZERO);
    full_hit_s = sb.issue && sb.issue_we && (sb.issue_addr != REG_ZERO) &&
                 (dst_cnt_s == CNT_MAX);
    stall_s    = sb.issue && (busy0_s || busy1_s || full_hit_s);
  end

  // Increment/decrement qualification. A writeback to an idle register is
  // dropped and flagged instead of wrapping the counter.
  always_comb begin
    inc_s       = sb.issue && !stall_s && sb.issue_we && (sb.issue_addr != REG_ZERO);
    dec_s       = sb.wb_we && (sb.wb_addr != REG_ZERO) && (wb_cnt_s != CNT_ZERO);
    underflow_s = sb.wb_we && (sb.wb_addr != REG_ZERO) && (wb_cnt_s == CNT_ZERO);
    if (inc_s) begin
      inc_vec_s = ONEHOT0 << sb.issue_addr;
    end else begin
      inc_vec_s = {NUM_REGS{1'b0}};
    end
    if (dec_s) begin
      dec_vec_s = ONEHOT0 << sb.wb_addr;
    end else begin
      dec_vec_s = {NUM_REGS{1'b0}};
    end
  end

  // Per-register next count. Flush wins over everything; an increment and
  // decrement landing on the same register cancel out.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      if (r == 0) begin
        cnt_nxt_s[r] = CNT_ZERO;
      end else if (sb.flush) begin
        cnt_nxt_s[r] = CNT_ZERO;
      end else if (inc_vec_s[r] && !dec_vec_s[r]) begin
        cnt_nxt_s[r] = cnt_r[r] + CNT_ONE;
      end else if (dec_vec_s[r] && !inc_vec_s[r]) begin
        cnt_nxt_s[r] = cnt_r[r] - CNT_ONE;
      end else begin
        cnt_nxt_s[r] = cnt_r[r];
      end
    end
  end

  // Running total kept in step with the counters so pending never needs an
  // adder tree across all registers. inc and dec on different registers
  // also net to zero.
  always_comb begin
    if (sb.flush) begin
      pending_nxt_s = 6'd0;
    end else if (inc_s && !dec_s) begin
      pending_nxt_s = pending_r + 6'd1;
    end else if (dec_s && !inc_s) begin
      pending_nxt_s = pending_r - 6'd1;
    end else begin
      pending_nxt_s = pending_r;
    end
  end

  // State registers. wb_err is sticky until reset and is not cleared by
  // flush; it is judged against the pre-flush counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_r[r] <= CNT_ZERO;
      end
      pending_r <= 6'd0;
      wb_err_r  <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_r[r] <= cnt_nxt_s[r];
      end
      pending_r <= pending_nxt_s;
      wb_err_r  <= wb_err_r | underflow_s;
    end
  end

  assign sb.stall   = stall_s;
  assign sb.busy0   = busy0_s;
  assign sb.busy1   = busy1_s;
  assign sb.pending = pending_r;
  assign sb.wb_err  = wb_err_r;

endmodule

// File: tb/tb_rf_scoreboard.sv
`timescale 1ns/1ps
module tb_rf_scoreboard;
  localparam int MAXC = 3;  // 2^CNT_W - 1 with CNT_W = 2

  logic clk = 1'b0;
  logic rst = 1'b1;

  rf_scoreboard_if u_if();

  rf_scoreboard #(.NUM_REGS(16), .CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (u_if.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: outstanding writes per register and the sticky error.
  int mcnt [16];
  bit merr;
  bit m_acc;
  bit m_decok;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int msum();
    int s = 0;
    for (int r = 0; r < 16; r++) s += mcnt[r];
    return s;
  endfunction

  function automatic bit mbusy(input logic [3:0] a, input logic re);
    return re && (a != 4'd0) && (mcnt[a] != 0);
  endfunction

  function automatic bit mstall();
    bit full;
    full = u_if.issue && u_if.issue_we && (u_if.issue_addr != 4'd0) &&
           (mcnt[u_if.issue_addr] == MAXC);
    return u_if.issue && (mbusy(u_if.src0_addr, u_if.src0_re) ||
                          mbusy(u_if.src1_addr, u_if.src1_re) || full);
  endfunction

  // Model update from the architectural rules at each rising edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 16; r++) mcnt[r] = 0;
      merr = 1'b0;
    end else begin
      m_acc   = u_if.issue && !mstall() && u_if.issue_we && (u_if.issue_addr != 4'd0);
      m_decok = u_if.wb_we && (u_if.wb_addr != 4'd0) && (mcnt[u_if.wb_addr] > 0);
      if (u_if.wb_we && (u_if.wb_addr != 4'd0) && (mcnt[u_if.wb_addr] == 0)) merr = 1'b1;
      if (u_if.flush) begin
        for (int r = 0; r < 16; r++) mcnt[r] = 0;
      end else begin
        if (m_acc) mcnt[u_if.issue_addr] = mcnt[u_if.issue_addr] + 1;
        if (m_decok) mcnt[u_if.wb_addr] = mcnt[u_if.wb_addr] - 1;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("busy0",   int'(u_if.busy0),   int'(mbusy(u_if.src0_addr, u_if.src0_re)));
    chk("busy1",   int'(u_if.busy1),   int'(mbusy(u_if.src1_addr, u_if.src1_re)));
    chk("stall",   int'(u_if.stall),   int'(mstall()));
    chk("pending", int'(u_if.pending), msum());
    chk("wb_err",  int'(u_if.wb_err),  int'(merr));
  end

  task automatic idle();
    u_if.src0_addr  = 4'd0;
    u_if.src0_re    = 1'b0;
    u_if.src1_addr  = 4'd0;
    u_if.src1_re    = 1'b0;
    u_if.issue      = 1'b0;
    u_if.issue_we   = 1'b0;
    u_if.issue_addr = 4'd0;
    u_if.wb_we      = 1'b0;
    u_if.wb_addr    = 4'd0;
    u_if.flush      = 1'b0;
    u_if.hlt        = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_we(input logic [3:0] a);
    u_if.issue      = 1'b1;
    u_if.issue_we   = 1'b1;
    u_if.issue_addr = a;
  endtask

  int start;
  int pick;

  initial begin
    idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_pending", int'(u_if.pending), 0);
    chk("reset_wb_err",  int'(u_if.wb_err),  0);

    // RAW hazard on R4
    issue_we(4'd4);
    step();
    idle();
    u_if.issue = 1'b1; u_if.src0_addr = 4'd4; u_if.src0_re = 1'b1;
    #1;
    chk("raw_stall", int'(u_if.stall), 1);
    chk("raw_busy0", int'(u_if.busy0), 1);
    u_if.wb_we = 1'b1; u_if.wb_addr = 4'd4;
    #1;
    chk("raw_stall_in_wb", int'(u_if.stall), 1);
    step();
    u_if.wb_we = 1'b0;
    #1;
    chk("raw_released", int'(u_if.stall),   0);
    chk("raw_pending",  int'(u_if.pending), 0);
    step();

    // Saturation on R7
    idle();
    issue_we(4'd7);
    repeat (3) step();
    #1;
    chk("sat_pending3", int'(u_if.pending), 3);
    chk("sat_stall",    int'(u_if.stall),   1);
    step();
    chk("sat_hold", int'(u_if.pending), 3);
    u_if.wb_we = 1'b1; u_if.wb_addr = 4'd7;
    step();
    u_if.wb_we = 1'b0;
    #1;
    chk("sat_accept", int'(u_if.stall), 0);
    step();
    chk("sat_refill", int'(u_if.pending), 3);
    idle();
    u_if.wb_we = 1'b1; u_if.wb_addr = 4'd7;
    repeat (3) step();
    idle();
    #1;
    chk("sat_drain", int'(u_if.pending), 0);
    step();

    // Simultaneous inc/dec on R2
    issue_we(4'd2);
    step();
    u_if.wb_we = 1'b1; u_if.wb_addr = 4'd2;
    #1;
    chk("sim_stall", int'(u_if.stall), 0);
    step();
    idle();
    u_if.src0_addr = 4'd2; u_if.src0_re = 1'b1;
    #1;
    chk("sim_pending", int'(u_if.pending), 1);
    chk("sim_busy0",   int'(u_if.busy0),   1);
    u_if.wb_we = 1'b1; u_if.wb_addr = 4'd2;
    step();
    idle();
    #1;
    chk("sim_drained", int'(u_if.pending), 0);
    step();

    // R0 is untracked; writeback underflow is sticky across flush
    issue_we(4'd0);
    u_if.src0_addr = 4'd0; u_if.src0_re = 1'b1;
    #1;
    chk("r0_stall", int'(u_if.stall), 0);
    step();
    idle();
    #1;
    chk("r0_pending", int'(u_if.pending), 0);
    u_if.wb_we = 1'b1; u_if.wb_addr = 4'd9;
    step();
    idle();
    #1;
    chk("uf_err",     int'(u_if.wb_err),  1);
    chk("uf_pending", int'(u_if.pending), 0);
    u_if.flush = 1'b1;
    step();
    idle();
    #1;
    chk("uf_err_after_flush", int'(u_if.wb_err), 1);
    step();

    // Flush with a concurrent issue
    issue_we(4'd1);
    step();
    step();
    u_if.issue_addr = 4'd6;
    step();
    idle();
    #1;
    chk("fl_pre_pending", int'(u_if.pending), 3);
    u_if.flush = 1'b1;
    issue_we(4'd3);
    step();
    idle();
    u_if.src0_addr = 4'd1; u_if.src0_re = 1'b1;
    u_if.src1_addr = 4'd6; u_if.src1_re = 1'b1;
    #1;
    chk("fl_pending", int'(u_if.pending), 0);
    chk("fl_busy_r1", int'(u_if.busy0),   0);
    chk("fl_busy_r6", int'(u_if.busy1),   0);
    u_if.src0_addr = 4'd3;
    #1;
    chk("fl_busy_r3", int'(u_if.busy0), 0);
    step();

    // Asynchronous reset mid-run with cnt[5]=2
    idle();
    issue_we(4'd5);
    step();
    step();
    idle();
    u_if.src0_addr = 4'd5; u_if.src0_re = 1'b1;
    #1;
    chk("rst_pre_busy0",   int'(u_if.busy0),   1);
    chk("rst_pre_pending", int'(u_if.pending), 2);
    rst = 1'b1;
    #1;
    chk("rst_pending", int'(u_if.pending), 0);
    chk("rst_busy0",   int'(u_if.busy0),   0);
    chk("rst_wb_err",  int'(u_if.wb_err),  0);
    step();
    rst = 1'b0;
    idle();
    step();

    // Randomized traffic, checked every cycle by the compare process
    for (int i = 0; i < 3000; i++) begin
      u_if.src0_addr  = 4'($urandom_range(0, 7));
      u_if.src0_re    = 1'($urandom_range(0, 1));
      u_if.src1_addr  = 4'($urandom_range(0, 7));
      u_if.src1_re    = 1'($urandom_range(0, 1));
      u_if.issue      = ($urandom_range(0, 3) != 0);
      u_if.issue_we   = ($urandom_range(0, 3) != 0);
      u_if.issue_addr = 4'($urandom_range(0, 7));
      u_if.wb_we      = 1'($urandom_range(0, 1));
      u_if.wb_addr    = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) begin
        start = $urandom_range(0, 15);
        for (int k = 0; k < 16; k++) begin
          pick = (start + k) % 16;
          if (mcnt[pick] != 0) begin
            u_if.wb_addr = 4'(pick);
            break;
          end
        end
      end
      u_if.flush = ($urandom_range(0, 39) == 0);
      u_if.hlt   = 1'($urandom_range(0, 1));
      step();
    end

    idle();
    step();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_scoreboard.md
# rf_scoreboard

Tracks register-file writes that have been issued but not yet written back, and holds the decode stage whenever a source operand or destination would collide with an in-flight write. Sits beside the 16x16 triple-ported register file: it watches the same read addresses/enables that decode presents to the file's p0/p1 ports and the same dst_addr/we that writeback presents to its write port. One saturating counter per architectural register; register 0 is never tracked.

## Interface

Parameters
- NUM_REGS, 16, number of architectural registers (address width fixed at 4)
- CNT_W, 2, per-register outstanding-write counter width; max outstanding per register = 2^CNT_W-1

Ports
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- src0_addr  input  4  decode read address, port 0 (same value driven to file p0_addr)
- src0_re  input  1  port 0 read enable
- src1_addr  input  4  decode read address, port 1
- src1_re  input  1  port 1 read enable
- issue  input  1  decode wants to issue an instruction this cycle
- issue_we  input  1  issuing instruction writes a register
- issue_addr  input  4  destination of issuing instruction
- wb_we  input  1  writeback writes the register file this cycle (same as file we)
- wb_addr  input  4  writeback destination (same as file dst_addr)
- flush  input  1  squash all in-flight writes (branch mispredict / halt)
- hlt  input  1  debug only: on rising edge, dump nonzero counters to simulation log
- stall  output  1  decode must hold; issue not accepted this cycle
- busy0  output  1  src0 operand has an outstanding write
- busy1  output  1  src1 operand has an outstanding write
- pending  output  6  total outstanding writes across all registers
- wb_err  output  1  sticky: writeback arrived for a register with count 0

## Operation

- State: cnt[r] for r=1..15, pending total, wb_err. cnt[0] reads as 0 always.
- busy0 = src0_re & (src0_addr!=0) & (cnt[src0_addr]!=0); busy1 likewise. Combinational from registered state.
- full_hit = issue & issue_we & (issue_addr!=0) & (cnt[issue_addr]==max).
- stall = issue & (busy0 | busy1 | full_hit). stall is 0 when issue is 0.
- accept = issue & ~stall. inc = accept & issue_we & (issue_addr!=0).
- dec = wb_we & (wb_addr!=0) & (cnt[wb_addr]!=0). If wb_we & wb_addr!=0 & cnt[wb_addr]==0: no decrement, wb_err set, and stays set until rst.
- Per register: inc only -> +1; dec only -> -1; inc and dec on the same register same cycle -> unchanged. Counters never wrap (inc blocked by full_hit, dec blocked at 0).
- pending = sum of cnt; updates by +1/-1/0 consistent with inc/dec; maximum 45.
- flush: at next rising edge all cnt and pending go to 0; overrides inc and dec that cycle; wb_err unaffected (wb_err from an ignored writeback in the flush cycle is still evaluated against pre-flush counts).
- hlt: non-synthesizable $display of R1..R15 counters; no functional effect.

## Timing

- Reset (async, rst high): all cnt=0, pending=0, wb_err=0; hence busy0=busy1=stall=0. Outputs valid immediately on rst assertion, not at a clock edge.
- Issue-to-busy latency: accepted issue at edge N makes busy visible from cycle N+1.
- Writeback-to-clear latency: decrement registered at the edge ending the wb cycle; busy drops the following cycle. A read in the same cycle as its writeback still stalls, matching the file's write-on-high-after-latch-on-low timing (data readable one cycle after wb).
- stall is combinational from state plus issue/src/issue inputs; no dependency on wb_we/wb_addr in the same cycle.
- Source and destination equal (e.g. R3 = R3 + R1) with R3 idle: not stalled; R3 becomes busy next cycle.

## Test plan

- Reset: assert rst mid-run with cnt[5]=2 -> pending=0, busy0=0 with src0_addr=5, src0_re=1, before next edge.
- RAW hazard: issue we to R4; next cycle issue with src0_addr=4 -> stall=1, busy0=1; wb_we R4 that cycle -> stall still 1; following cycle stall=0, pending=0.
- Saturation: three accepted issues to R7 with no wb -> cnt=3, pending=3; fourth issue to R7 -> stall=1, pending stays 3; one wb R7 -> next cycle fourth issue accepted.
- Simultaneous inc/dec: cnt[2]=1, same cycle issue we R2 and wb R2 -> cnt[2]=1, pending unchanged.
- R0 and underflow: issue we R0 -> pending unchanged, no stall on src R0; wb_we R9 with cnt[9]=0 -> wb_err=1, pending unchanged, remains 1 after flush.
- Flush: cnt[1]=2, cnt[6]=1, flush with concurrent issue R3 -> next cycle pending=0, no busy on R1/R3/R6.
